// File: rtl/dma_write_master_if.sv
// AHB-lite bus bundle between the write-back DMA (master) and memory (slave).
//   O_DW_HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA : master -> slave
//   I_DW_HREADY/I_DW_HRESP                        : slave  -> master
interface dma_write_master_if;
  logic [31:0] O_DW_HADDR;
  logic [1:0]  O_DW_HTRANS;
  logic        O_DW_HWRITE;
  logic [2:0]  O_DW_HSIZE;
  logic [2:0]  O_DW_HBURST;
  logic [31:0] O_DW_HWDATA;
  logic        I_DW_HREADY;
  logic        I_DW_HRESP;

  modport master (
    output O_DW_HADDR, O_DW_HTRANS, O_DW_HWRITE, O_DW_HSIZE, O_DW_HBURST, O_DW_HWDATA,
    input  I_DW_HREADY, I_DW_HRESP
  );

  modport slave (
    input  O_DW_HADDR, O_DW_HTRANS, O_DW_HWRITE, O_DW_HSIZE, O_DW_HBURST, O_DW_HWDATA,
    output I_DW_HREADY, I_DW_HRESP
  );
endinterface

// File: rtl/dma_write_master.sv
// dma_write_master: drains one rotated block (P_BURSTS x P_BEATS words) from
// the output pixel buffer to memory as back-to-back INCR8 AHB-lite writes.
//   I_DW_HCLK, I_DW_RESET  clock, synchronous active-high reset
//   I_DW_START             pulse: buffer full, start write-back
//   I_DW_BASE_ADDR         destination byte address, low 5 bits ignored
//   O_DW_BUF_ADDR          buffer word index (comb), I_DW_BUF_RDATA 1 cycle later
//   ahb                    AHB-lite master port (dma_write_master_if.master)
//   O_DW_BUSY/DONE/ERROR   status: busy, completion pulse, sticky bus error
// Build option: define DW_BYTE_SWAP_EN to byte-reverse each word for
// big-endian memory; timing is unchanged.
module dma_write_master #(
  parameter int P_BEATS  = 8,
  parameter int P_BURSTS = 6
) (
  input  logic                     I_DW_HCLK,
  input  logic                     I_DW_RESET,
  input  logic                     I_DW_START,
  input  logic [31:0]              I_DW_BASE_ADDR,
  output logic [5:0]               O_DW_BUF_ADDR,
  input  logic [31:0]              I_DW_BUF_RDATA,
  dma_write_master_if.master       ahb,
  output logic                     O_DW_BUSY,
  output logic                     O_DW_DONE,
  output logic                     O_DW_ERROR
);
  localparam int BW = (P_BEATS  > 1) ? $clog2(P_BEATS)  : 1;
  localparam int RW = (P_BURSTS > 1) ? $clog2(P_BURSTS) : 1;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_BURST, S_LAST, S_ERR, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q;
  logic [RW-1:0]   burst_q;
  logic [31:0]     base_q;
  logic [31:0]     hwdata_q;
  logic            dphase_q;   // a write data phase is outstanding
  logic            error_q;
  logic [5:0]      k;
  logic [31:0]     wdata_in;
  logic            acc, last_beat, last_word, bus_err;

  assign k         = 6'(burst_q) * 6'(P_BEATS) + 6'(beat_q);
  assign acc       = (state_q == S_BURST) && ahb.I_DW_HREADY;
  assign last_beat = (beat_q == BW'(P_BEATS - 1));
  assign last_word = last_beat && (burst_q == RW'(P_BURSTS - 1));
  // First cycle of a two-cycle ERROR response during our data phase.
  assign bus_err   = dphase_q && ahb.I_DW_HRESP && !ahb.I_DW_HREADY;

  // Look one word ahead on accept so RDATA always carries the word whose
  // address phase is on the bus next cycle, wait states included.
  assign O_DW_BUF_ADDR = k + {5'b0, acc};

`ifdef DW_BYTE_SWAP_EN
  assign wdata_in = {I_DW_BUF_RDATA[7:0], I_DW_BUF_RDATA[15:8],
                     I_DW_BUF_RDATA[23:16], I_DW_BUF_RDATA[31:24]};
`else
  assign wdata_in = I_DW_BUF_RDATA;
`endif

  // State register
  always_ff @(posedge I_DW_HCLK) begin
    if (I_DW_RESET) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (I_DW_START) state_d = S_FETCH;
      S_FETCH: state_d = S_BURST;
      S_BURST: if (bus_err) state_d = S_ERR;
               else if (acc && last_word) state_d = S_LAST;
      S_LAST:  if (bus_err) state_d = S_ERR;
               else if (ahb.I_DW_HREADY) state_d = S_DONE;
      S_ERR:   if (ahb.I_DW_HREADY) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ahb.O_DW_HSIZE  = 3'b010;
    ahb.O_DW_HBURST = 3'b101;
    ahb.O_DW_HWDATA = hwdata_q;
    ahb.O_DW_HTRANS = HT_IDLE;
    ahb.O_DW_HWRITE = 1'b0;
    ahb.O_DW_HADDR  = 32'h0;
    if (state_q == S_BURST) begin
      ahb.O_DW_HTRANS = (beat_q == '0) ? HT_NONSEQ : HT_SEQ;
      ahb.O_DW_HWRITE = 1'b1;
      ahb.O_DW_HADDR  = base_q + {24'h0, k, 2'b00};
    end
    O_DW_BUSY  = (state_q != S_IDLE) && (state_q != S_DONE);
    O_DW_DONE  = (state_q == S_DONE);
    O_DW_ERROR = error_q;
  end

  // Datapath: counters, base, write data, data-phase tracking, error flag
  always_ff @(posedge I_DW_HCLK) begin
    if (I_DW_RESET) begin
      beat_q   <= '0;
      burst_q  <= '0;
      base_q   <= 32'h0;
      hwdata_q <= 32'h0;
      dphase_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && I_DW_START) begin
        base_q  <= {I_DW_BASE_ADDR[31:5], 5'b0};
        error_q <= 1'b0;
      end else if (bus_err) begin
        error_q <= 1'b1;
      end

      // Counters only live in BURST; elsewhere they park at 0 so FETCH
      // presents buffer word 0.
      if (state_q != S_BURST) begin
        beat_q  <= '0;
        burst_q <= '0;
      end else if (acc) begin
        if (last_beat) begin
          beat_q  <= '0;
          burst_q <= burst_q + RW'(1);
        end else begin
          beat_q  <= beat_q + BW'(1);
        end
      end

      if (acc) hwdata_q <= wdata_in;

      // A data phase ends when HREADY is high; a new one starts on accept.
      if (ahb.I_DW_HREADY) dphase_q <= acc;
    end
  end
endmodule

// File: tb/tb_dma_write_master.sv
module tb_dma_write_master;
  logic        clk;
  logic        rst, start;
  logic [31:0] base_addr, buf_rdata;
  logic [5:0]  buf_addr;
  logic        busy, done, error;
  logic [31:0] bufmem [64];

  dma_write_master_if bus();

  dma_write_master dut (
    .I_DW_HCLK(clk), .I_DW_RESET(rst), .I_DW_START(start),
    .I_DW_BASE_ADDR(base_addr), .O_DW_BUF_ADDR(buf_addr),
    .I_DW_BUF_RDATA(buf_rdata), .ahb(bus.master),
    .O_DW_BUSY(busy), .O_DW_DONE(done), .O_DW_ERROR(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous buffer: data one cycle after address
  always @(posedge clk) buf_rdata <= bufmem[buf_addr];

  int checks = 0;
  int failures = 0;
  int test_id = 0;
  logic [31:0] tbase = 32'h0;

  // Bus observer (mid-cycle): logs accepted addresses and completed writes
  logic [31:0] wr_addr [512];
  logic [31:0] wr_data [512];
  logic [31:0] acc_addr [512];
  logic [1:0]  acc_trans [512];
  int nwr = 0, na = 0, ndone = 0, done_cyc = 0;
  bit dph_v = 0;
  logic [31:0] dph_a = 0;

  always @(negedge clk) begin
    if (dph_v && bus.I_DW_HREADY === 1'b1) begin
      if (nwr < 512) begin wr_addr[nwr] = dph_a; wr_data[nwr] = bus.O_DW_HWDATA; end
      nwr++;
      dph_v = 0;
    end
    if (bus.I_DW_HREADY === 1'b1 && bus.O_DW_HTRANS[1] === 1'b1) begin
      dph_v = 1;
      dph_a = bus.O_DW_HADDR;
      if (na < 512) begin acc_addr[na] = bus.O_DW_HADDR; acc_trans[na] = bus.O_DW_HTRANS; end
      na++;
    end
    if (done === 1'b1) begin ndone++; done_cyc = cyc; end
  end

  // Slave response driver: wait states / error injection per test
  int stall_left = 0, err_left = 0, nstall = 0, unstable = 0, last_id = -1;
  bit hit_a = 0, hit_b = 0, hit_e = 0;
  logic [31:0] s_addr = 0, s_data = 0, max_pres = 0;
  logic [1:0]  s_trans = 0, err_b_trans = 2'b11;

  always @(posedge clk) begin
    #1;
    if (test_id != last_id) begin
      last_id = test_id; hit_a = 0; hit_b = 0; hit_e = 0; max_pres = 0;
    end
    if (bus.O_DW_HTRANS != 2'b00 && bus.O_DW_HADDR > max_pres) max_pres = bus.O_DW_HADDR;
    bus.I_DW_HREADY = 1'b1;
    bus.I_DW_HRESP  = 1'b0;
    if (err_left > 0) begin
      bus.I_DW_HRESP = 1'b1;
      err_left--;
      err_b_trans = bus.O_DW_HTRANS;
    end else if (stall_left > 0) begin
      bus.I_DW_HREADY = 1'b0;
      stall_left--;
      nstall++;
      if (bus.O_DW_HADDR !== s_addr || bus.O_DW_HTRANS !== s_trans || bus.O_DW_HWDATA !== s_data)
        unstable++;
    end else if (bus.O_DW_HTRANS != 2'b00) begin
      if (test_id == 2 && ((!hit_a && bus.O_DW_HADDR == tbase + 20) ||
                           (!hit_b && bus.O_DW_HADDR == tbase + 32))) begin
        if (bus.O_DW_HADDR == tbase + 20) hit_a = 1; else hit_b = 1;
        bus.I_DW_HREADY = 1'b0;
        stall_left = 2;
        nstall++;
        s_addr = bus.O_DW_HADDR; s_trans = bus.O_DW_HTRANS; s_data = bus.O_DW_HWDATA;
      end else if (test_id == 3 && !hit_e && bus.O_DW_HADDR == tbase + 44) begin
        hit_e = 1;
        bus.I_DW_HRESP  = 1'b1;
        bus.I_DW_HREADY = 1'b0;
        err_left = 1;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(logic [31:0] pat);
    for (int i = 0; i < 64; i++) bufmem[i] = pat + i;
  endtask

  task automatic run_start(logic [31:0] b, output int c0);
    base_addr = b;
    start = 1'b1;
    c0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(int nd0, string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (ndone > nd0) begin ok = 1; break; end
      tick(1);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_addr(logic [31:0] a, string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.O_DW_HADDR == a && bus.O_DW_HTRANS != 2'b00) begin ok = 1; break; end
      tick(1);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] exp_word(logic [31:0] w);
`ifdef DW_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk_block(string t, int w0, int a0, logic [31:0] b, logic [31:0] pat);
    chk({t, "_nwr"}, 32'(nwr - w0), 32'd48);
    chk({t, "_nacc"}, 32'(na - a0), 32'd48);
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("%s_addr%0d", t, i), wr_addr[w0 + i], b + 32'(4 * i));
      chk($sformatf("%s_data%0d", t, i), wr_data[w0 + i], exp_word(pat + 32'(i)));
      chk($sformatf("%s_trans%0d", t, i), 32'(acc_trans[a0 + i]),
          (i % 8 == 0) ? 32'd2 : 32'd3);
    end
  endtask

  initial begin
    int c0, w0, a0, nd0, ns0, un0;
    rst = 1'b1; start = 1'b0; base_addr = 32'h0;
    fill(32'h0);
    tick(3);
    // Reset state
    chk("rst_htrans", 32'(bus.O_DW_HTRANS), 32'd0);
    chk("rst_haddr", bus.O_DW_HADDR, 32'h0);
    chk("rst_hwdata", bus.O_DW_HWDATA, 32'h0);
    chk("rst_hwrite", 32'(bus.O_DW_HWRITE), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_bufaddr", 32'(buf_addr), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: zero wait states
    test_id = 1; tbase = 32'h1000_0040; fill(32'hA0A0_0000);
    nd0 = ndone; w0 = nwr; a0 = na;
    run_start(32'h1000_0040, c0);
    chk("t1_fetch_busy", 32'(busy), 32'd1);
    chk("t1_fetch_htrans", 32'(bus.O_DW_HTRANS), 32'd0);
    wait_done(nd0, "t1_done_seen");
    chk("t1_done_cycle", 32'(done_cyc - c0), 32'd51);
    chk("t1_hsize", 32'(bus.O_DW_HSIZE), 32'd2);
    chk("t1_hburst", 32'(bus.O_DW_HBURST), 32'd5);
    tick(2);
    chk("t1_done_count", 32'(ndone - nd0), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_error", 32'(error), 32'd0);
    chk_block("t1", w0, a0, 32'h1000_0040, 32'hA0A0_0000);

    // 2: 3-cycle waits at k=5 and k=8
    test_id = 2; tbase = 32'h1000_0040;
    nd0 = ndone; w0 = nwr; a0 = na; ns0 = nstall; un0 = unstable;
    run_start(32'h1000_0040, c0);
    wait_done(nd0, "t2_done_seen");
    chk("t2_done_cycle", 32'(done_cyc - c0), 32'd57);
    chk("t2_stalls", 32'(nstall - ns0), 32'd6);
    chk("t2_stable", 32'(unstable - un0), 32'd0);
    tick(2);
    chk_block("t2", w0, a0, 32'h1000_0040, 32'hA0A0_0000);

    // 3: ERROR response in data phase of k=10
    test_id = 3; tbase = 32'h1000_0040; fill(32'hB0B0_0000);
    nd0 = ndone; w0 = nwr; a0 = na;
    run_start(32'h1000_0040, c0);
    wait_done(nd0, "t3_done_seen");
    chk("t3_done_cycle", 32'(done_cyc - c0), 32'd15);
    chk("t3_cancel_htrans", 32'(err_b_trans), 32'd0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_max_addr", max_pres, 32'h1000_0040 + 32'd44);
    chk("t3_nacc", 32'(na - a0), 32'd11);
    chk("t3_last_acc", acc_addr[a0 + 10], 32'h1000_0040 + 32'd40);
    tick(2);
    chk("t3_done_count", 32'(ndone - nd0), 32'd1);
    chk("t3_error_sticky", 32'(error), 32'd1);

    // 4: unaligned base, START clears ERROR, word 0 = 0x11223344
    test_id = 4; tbase = 32'h2000_0000; fill(32'hC0C0_0000);
    bufmem[0] = 32'h1122_3344;
    nd0 = ndone; w0 = nwr; a0 = na;
    run_start(32'h2000_001F, c0);
    chk("t4_error_cleared", 32'(error), 32'd0);
    chk("t4_fetch_bufaddr", 32'(buf_addr), 32'd0);
    wait_done(nd0, "t4_done_seen");
    chk("t4_nwr", 32'(nwr - w0), 32'd48);
    chk("t4_first_addr", wr_addr[w0], 32'h2000_0000);
    chk("t4_last_addr", wr_addr[w0 + 47], 32'h2000_00BC);
    chk("t4_word0", wr_data[w0], exp_word(32'h1122_3344));
    chk("t4_word47", wr_data[w0 + 47], exp_word(32'hC0C0_002F));
    tick(2);

    // 5: START during BURST ignored, reset at k=20
    test_id = 5; tbase = 32'h3000_0000; fill(32'hD0D0_0000);
    nd0 = ndone;
    run_start(32'h3000_0000, c0);
    wait_addr(32'h3000_000C, "t5_reach_k3");
    start = 1'b1; base_addr = 32'h4000_0000;
    tick(1);
    start = 1'b0;
    chk("t5_ignore_haddr", bus.O_DW_HADDR, 32'h3000_0010);
    chk("t5_ignore_busy", 32'(busy), 32'd1);
    wait_addr(32'h3000_0050, "t5_reach_k20");
    rst = 1'b1;
    tick(1);
    chk("t5_rst_htrans", 32'(bus.O_DW_HTRANS), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_haddr", bus.O_DW_HADDR, 32'h0);
    chk("t5_rst_hwdata", bus.O_DW_HWDATA, 32'h0);
    chk("t5_rst_bufaddr", 32'(buf_addr), 32'd0);
    rst = 1'b0;
    tick(5);
    chk("t5_no_done", 32'(ndone - nd0), 32'd0);
    chk("t5_idle_htrans", 32'(bus.O_DW_HTRANS), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_write_master.md
Name: dma_write_master

Overview:
- Drains one rotated block (64 RGB pixels = 192 bytes = 48 words) from the output pixel buffer into system memory.
- Acts as an AHB-lite write master issuing six back-to-back INCR8 word bursts.
- Is the write-side counterpart of the pixel address core: the core fills the output buffer, and this block empties it and reports completion so the core/DMA can start the next read pass.

Parameters:
- P_BEATS, 8, beats per burst (HBURST fixed INCR8).
- P_BURSTS, 6, bursts per block; total words = P_BEATS*P_BURSTS = 48.

Ports:
- I_DW_HCLK  in  1  system clock
- I_DW_RESET  in  1  synchronous reset, active-high
- I_DW_START  in  1  one-cycle pulse: output buffer full, begin write-back
- I_DW_BASE_ADDR  in  32  destination byte address; bits [4:0] ignored (treated as 0)
- O_DW_BUF_ADDR  out  6  output-buffer word index (combinational)
- I_DW_BUF_RDATA  in  32  buffer read data, valid one cycle after O_DW_BUF_ADDR
- O_DW_HADDR  out  32  AHB address
- O_DW_HTRANS  out  2  IDLE=0, NONSEQ=2, SEQ=3
- O_DW_HWRITE  out  1  1 during transfers
- O_DW_HSIZE  out  3  constant 3'b010 (word)
- O_DW_HBURST  out  3  constant 3'b101 (INCR8)
- O_DW_HWDATA  out  32  write data (registered)
- I_DW_HREADY  in  1  transfer ready
- I_DW_HRESP  in  1  0=OKAY, 1=ERROR
- O_DW_BUSY  out  1  high from FETCH until return to IDLE
- O_DW_DONE  out  1  one-cycle pulse, block complete or aborted
- O_DW_ERROR  out  1  sticky error flag; cleared by reset or next accepted START

Behaviour:
- Reset (sync, I_DW_RESET=1 at edge, including mid-burst): state IDLE.
  - HTRANS=0, HADDR=0, HWDATA=0, HWRITE=0, BUSY=0, DONE=0, ERROR=0.
  - Beat/burst counters=0; BUF_ADDR=0.
  - Reset during a burst abandons it; no completion pulse.
- Address register: `base_q` = {I_DW_BASE_ADDR[31:5],5'b0}, captured on accepted START.
- States:
  - IDLE: START=1 -> FETCH; clears ERROR, captures `base_q`. START while not IDLE is ignored.
  - FETCH (1 cycle): BUF_ADDR=0, HTRANS=IDLE -> BURST.
  - BURST: word index k (0..47) is in address phase.
    - HADDR = `base_q` + 4k.
    - HTRANS = NONSEQ when k mod 8 = 0, else SEQ.
    - When HREADY=1 the address phase is accepted: HWDATA <= I_DW_BUF_RDATA (= word k), k++.
    - Accept of k=47 -> LAST.
  - LAST: HTRANS=IDLE, HWDATA held; HREADY=1 -> DONE.
  - DONE (1 cycle): O_DW_DONE=1, BUSY=0 -> IDLE.
- Buffer addressing: O_DW_BUF_ADDR = k + (HREADY & in-address-phase), so BUF_RDATA always equals word k during k's address phase, including under wait states.
- Pipelining:
  - Data phase of word k overlaps address phase of word k+1.
  - HWDATA is held stable while HREADY=0.
  - Burst boundaries are back-to-back; no IDLE is inserted between bursts.
- Latency, zero wait states: START at cycle 0; FETCH cycle 1; address phases cycles 2..49; last data phase cycle 50; DONE=1 at cycle 51.
- HRESP=1 in any data phase (first error cycle, HREADY=0):
  - Next cycle HTRANS=IDLE, cancelling the pending address.
  - Set ERROR; go to DONE after the second error cycle.
  - Remaining words are not written.
- Arithmetic: HADDR wraps modulo 2^32; no 1KB boundary crossing is possible given 32-byte alignment.

Optional Feature:
- DW_BYTE_SWAP_EN defined: HWDATA loaded with byte-reversed word ({b0,b1,b2,b3}) for big-endian memory.
- Undefined: word passed unchanged.
- Timing identical in both cases.

Test Plan:
- BASE=0x1000_0040, buffer word i = 0xA0A0_0000+i, HREADY=1, START pulse -> 48 writes at 0x1000_0040..0x1000_00FC; NONSEQ at k=0,8,..,40; HWDATA match word k one cycle after each address; DONE at cycle 51.
- Same, with HREADY=0 for 3 cycles at k=5 and k=8 -> HADDR/HTRANS/HWDATA held stable during waits; all 48 words correct; DONE delayed 6 cycles.
- BASE=0x2000_001F -> first HADDR=0x2000_0000; last HADDR=0x2000_00BC.
- HRESP=1 two cycles during data phase of k=10 -> HTRANS=IDLE next cycle, ERROR=1, DONE pulse, no address ≥ k=12; next START clears ERROR.
- START pulsed during BURST -> ignored; RESET asserted at k=20 -> HTRANS=0, BUSY=0 next edge, no DONE.
- With DW_BYTE_SWAP_EN: word 0x1122_3344 -> HWDATA 0x4433_2211.
